progmem_arbiter: RTL

PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

---
 rtl/progmem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/progmem_arbiter.sv
// rtl/progmem_arbiter.sv - round-robin arbiter sharing one byte-wide program memory port
//
// Purpose: serves two requesters from a single-port, one-cycle-latency byte memory.
//   Instruction fetch reads 3 bytes at if_addr.
//   Constant pool reads 4 bytes at cp_index*4.
//   Bytes are assembled big-endian. Each result is returned with a one-cycle valid pulse.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   if_req, if_addr     fetch request and base address
//   if_valid, if_data   fetch completion pulse and {opcode, arg1, arg2}
//   cp_req, cp_index    constant-pool request and constant index
//   cp_valid, cp_data   constant completion pulse and 32-bit constant
//   mem_addr, mem_rdata memory byte address out; read data back one cycle later
//   busy                high whenever a transaction is in progress

module progmem_arbiter #(
    parameter int SIZE   = 65536,
    parameter int PC_LEN = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [PC_LEN-1:0] if_addr,
    output logic              if_valid,
    output logic [23:0]       if_data,
    input  logic              cp_req,
    input  logic [7:0]        cp_index,
    output logic              cp_valid,
    output logic [31:0]       cp_data,
    output logic [PC_LEN-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    localparam logic [PC_LEN:0] SIZE_W = (PC_LEN + 1)'(SIZE);

    state_t            state;
    state_t            state_next;

    logic              gnt_cp;     // current transaction belongs to the constant pool
    logic              last_cp;    // last grant went to the constant pool
    logic [PC_LEN-1:0] base;
    logic [1:0]        last_idx;   // N-1 for the current transaction
    logic [1:0]        issue_cnt;
    logic [1:0]        cap_cnt;
    logic              pend;       // an issued address has data arriving this cycle
    logic [23:0]       asm_reg;    // bytes captured so far, newest in the low byte
    logic [23:0]       if_data_r;
    logic [31:0]       cp_data_r;

    logic              grant;
    logic              grant_cp;
    logic              capture;
    logic              last_cap;
    logic [PC_LEN-1:0] cp_base;
    logic [PC_LEN:0]   addr_sum;
    logic [PC_LEN:0]   addr_wrap;

    // Tie goes to whoever was not granted last; a lone request always wins.
    assign grant    = (state == IDLE) && (if_req || cp_req);
    assign grant_cp = cp_req && (!if_req || !last_cp);

    // Data for address issued in READ cycle j arrives in cycle j+1, so
    // capturing starts one cycle after entering READ.
    assign capture  = (state == READ) && pend;
    assign last_cap = capture && (cap_cnt == last_idx);

    assign cp_base  = PC_LEN'(((32'(cp_index)) << 2) % 32'(SIZE));

    // base < SIZE and issue_cnt <= 3, so a single conditional subtract wraps.
    assign addr_sum  = {1'b0, base} + (PC_LEN + 1)'(issue_cnt);
    assign addr_wrap = (addr_sum >= SIZE_W) ? (addr_sum - SIZE_W) : addr_sum;

    assign mem_addr = (state == READ) ? addr_wrap[PC_LEN-1:0] : '0;
    assign busy     = (state != IDLE);
    // Reset in the DONE cycle suppresses the pulse that would otherwise escape.
    assign if_valid = (state == DONE) && !gnt_cp && !rst;
    assign cp_valid = (state == DONE) &&  gnt_cp && !rst;
    assign if_data  = if_data_r;
    assign cp_data  = cp_data_r;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = READ;
            READ:    if (last_cap) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_cp    <= 1'b0;
            last_cp   <= 1'b1;
            base      <= '0;
            last_idx  <= 2'd0;
            issue_cnt <= 2'd0;
            cap_cnt   <= 2'd0;
            pend      <= 1'b0;
            asm_reg   <= 24'd0;
            if_data_r <= 24'd0;
            cp_data_r <= 32'd0;
        end else begin
            state <= state_next;
            if (grant) begin
                gnt_cp    <= grant_cp;
                last_cp   <= grant_cp;
                base      <= grant_cp ? cp_base : if_addr;
                last_idx  <= grant_cp ? 2'd3 : 2'd2;
                issue_cnt <= 2'd0;
                cap_cnt   <= 2'd0;
                pend      <= 1'b0;
                asm_reg   <= 24'd0;
            end else if (state == READ) begin
                pend <= 1'b1;
                if (issue_cnt != last_idx) begin
                    issue_cnt <= issue_cnt + 2'd1;
                end
                if (capture) begin
                    asm_reg <= {asm_reg[15:0], mem_rdata};
                    cap_cnt <= cap_cnt + 2'd1;
                end
                if (last_cap) begin
                    if (gnt_cp) begin
                        cp_data_r <= {asm_reg, mem_rdata};
                    end else begin
                        if_data_r <= {asm_reg[15:0], mem_rdata};
                    end
                end
            end
        end
    end

endmodule
